// File: rtl/seq_pkg.sv
// Shared constants for the stage sequencer: stage indices, default parameters
// and the elaboration-time mode selectors.
package seq_pkg;

  localparam int STG_F = 0;
  localparam int STG_D = 1;
  localparam int STG_E = 2;
  localparam int STG_M = 3;
  localparam int STG_W = 4;

  localparam int DEF_NUM_STAGES  = 5;
  localparam int DEF_PIPELINED   = 0;
  localparam int DEF_FLUSH_STAGE = 2;
  localparam int DEF_CNT_W       = 32;

  localparam int SEQ_MULTI = 0;
  localparam int SEQ_PIPE  = 1;

  // Stages strictly younger than the branch-resolving stage.
  function automatic logic [7:0] younger_mask(input int fs);
    return 8'((1 << fs) - 1);
  endfunction

endpackage

// File: rtl/retire_counter.sv
// Free-running event counter with increment enable and asynchronous clear;
// wraps silently from all-ones to zero.
module retire_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign count_d = inc_i ? count_q + CNT_W'(1) : count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/stage_sequencer.sv
// Per-stage enable generator for the CPU datapath: either a single rotating
// token (multi-cycle) or per-stage valid bits with stall and branch flush.
module stage_sequencer
  import seq_pkg::*;
#(
  parameter int NUM_STAGES  = DEF_NUM_STAGES,
  parameter int PIPELINED   = DEF_PIPELINED,
  parameter int FLUSH_STAGE = DEF_FLUSH_STAGE,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic                  sysclk,
  input  logic                  cpu_resetn,
  input  logic                  run_i,
  input  logic [NUM_STAGES-1:0] stall_i,
  input  logic                  flush_i,
  output logic [NUM_STAGES-1:0] stage_en_o,
  output logic [NUM_STAGES-1:0] stage_valid_o,
  output logic                  retire_o,
  output logic                  busy_o,
  output logic [CNT_W-1:0]      instr_count_o
);

  localparam int LAST = NUM_STAGES - 1;

  logic [NUM_STAGES-1:0] en_w;
  logic [NUM_STAGES-1:0] valid_w;

  generate
    if (PIPELINED == SEQ_PIPE) begin : g_pipe
      localparam logic [NUM_STAGES-1:0] YOUNGER = NUM_STAGES'(younger_mask(FLUSH_STAGE));

      logic [NUM_STAGES-1:0] v_q;
      logic [NUM_STAGES-1:0] v_d;
      logic [NUM_STAGES-1:0] adv;
      logic [NUM_STAGES-1:0] kill;

      // A stage advances when the stage ahead is empty or itself advancing.
      always_comb begin : adv_chain
        logic room;
        room = 1'b1;
        adv  = '0;
        for (int k = LAST; k >= 0; k--) begin
          adv[k] = v_q[k] & ~stall_i[k] & room;
          room   = ~v_q[k] | adv[k];
        end
      end

      assign kill = flush_i ? YOUNGER : '0;
      assign en_w = adv & ~kill;
      assign v_d  = {en_w[LAST-1:0], run_i} | (v_q & ~adv & ~kill);

      always_ff @(posedge sysclk or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
          v_q <= '0;
        end else begin
          v_q <= v_d;
        end
      end

      assign valid_w = v_q;
    end else begin : g_multi
      logic [NUM_STAGES-1:0] tok_q;
      logic [NUM_STAGES-1:0] tok_d;
      logic                  unused_flush;

      assign unused_flush = flush_i;
      assign en_w  = tok_q & ~stall_i;
      // Stalled token holds; completed token moves on; stage 0 loads from idle or wrap.
      assign tok_d = (tok_q & stall_i)
                   | {en_w[LAST-1:0], ((tok_q == '0) | en_w[LAST]) & run_i};

      always_ff @(posedge sysclk or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
          tok_q <= '0;
        end else begin
          tok_q <= tok_d;
        end
      end

      assign valid_w = tok_q;
    end
  endgenerate

  assign stage_en_o    = en_w;
  assign stage_valid_o = valid_w;
  assign retire_o      = en_w[LAST];
  assign busy_o        = |valid_w;

  retire_counter #(
    .CNT_W(CNT_W)
  ) u_retire_cnt (
    .clk_i  (sysclk),
    .rst_ni (cpu_resetn),
    .inc_i  (retire_o),
    .count_o(instr_count_o)
  );

endmodule
